// File: rtl/axi_rr_arbiter.sv
// Round-robin arbiter sharing one AXI4 master port among NUM_REQ requesters.
// Write (AW/W/B) and read (AR/R) paths are arbitrated independently, with one
// outstanding burst per direction. Granted-requester payloads are forwarded
// combinationally and responses are steered back to the current grant holder.
module axi_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 16,
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 512,
    parameter int LEN_W   = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ*ID_W-1:0]        s_awid,
    input  logic [NUM_REQ*ADDR_W-1:0]      s_awaddr,
    input  logic [NUM_REQ*LEN_W-1:0]       s_awlen,
    input  logic [NUM_REQ*3-1:0]           s_awsize,
    input  logic [NUM_REQ*2-1:0]           s_awburst,
    input  logic [NUM_REQ-1:0]             s_awvalid,
    output logic [NUM_REQ-1:0]             s_awready,
    input  logic [NUM_REQ*DATA_W-1:0]      s_wdata,
    input  logic [NUM_REQ*DATA_W/8-1:0]    s_wstrb,
    input  logic [NUM_REQ-1:0]             s_wlast,
    input  logic [NUM_REQ-1:0]             s_wvalid,
    output logic [NUM_REQ-1:0]             s_wready,
    output logic [NUM_REQ*ID_W-1:0]        s_bid,
    output logic [NUM_REQ*2-1:0]           s_bresp,
    output logic [NUM_REQ-1:0]             s_bvalid,
    input  logic [NUM_REQ-1:0]             s_bready,
    input  logic [NUM_REQ*ID_W-1:0]        s_arid,
    input  logic [NUM_REQ*ADDR_W-1:0]      s_araddr,
    input  logic [NUM_REQ*LEN_W-1:0]       s_arlen,
    input  logic [NUM_REQ*3-1:0]           s_arsize,
    input  logic [NUM_REQ*2-1:0]           s_arburst,
    input  logic [NUM_REQ-1:0]             s_arvalid,
    output logic [NUM_REQ-1:0]             s_arready,
    output logic [NUM_REQ*ID_W-1:0]        s_rid,
    output logic [NUM_REQ*DATA_W-1:0]      s_rdata,
    output logic [NUM_REQ*2-1:0]           s_rresp,
    output logic [NUM_REQ-1:0]             s_rlast,
    output logic [NUM_REQ-1:0]             s_rvalid,
    input  logic [NUM_REQ-1:0]             s_rready,
    output logic [ID_W-1:0]                m_awid,
    output logic [ADDR_W-1:0]              m_awaddr,
    output logic [LEN_W-1:0]               m_awlen,
    output logic [2:0]                     m_awsize,
    output logic [1:0]                     m_awburst,
    output logic                           m_awlock,
    output logic [3:0]                     m_awcache,
    output logic [2:0]                     m_awprot,
    output logic [3:0]                     m_awqos,
    output logic [3:0]                     m_awregion,
    output logic [0:0]                     m_awuser,
    output logic                           m_awvalid,
    input  logic                           m_awready,
    output logic [DATA_W-1:0]              m_wdata,
    output logic [DATA_W/8-1:0]            m_wstrb,
    output logic                           m_wlast,
    output logic                           m_wvalid,
    input  logic                           m_wready,
    input  logic [ID_W-1:0]                m_bid,
    input  logic [1:0]                     m_bresp,
    input  logic                           m_bvalid,
    output logic                           m_bready,
    output logic [ID_W-1:0]                m_arid,
    output logic [ADDR_W-1:0]              m_araddr,
    output logic [LEN_W-1:0]               m_arlen,
    output logic [2:0]                     m_arsize,
    output logic [1:0]                     m_arburst,
    output logic                           m_arlock,
    output logic [3:0]                     m_arcache,
    output logic [2:0]                     m_arprot,
    output logic [3:0]                     m_arqos,
    output logic [3:0]                     m_arregion,
    output logic [0:0]                     m_aruser,
    output logic                           m_arvalid,
    input  logic                           m_arready,
    input  logic [ID_W-1:0]                m_rid,
    input  logic [DATA_W-1:0]              m_rdata,
    input  logic [1:0]                     m_rresp,
    input  logic                           m_rlast,
    input  logic                           m_rvalid,
    output logic                           m_rready
);
    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_BUSY = 2'd1, W_RESP = 2'd2} w_state_t;
    typedef enum logic [1:0] {R_IDLE = 2'd0, R_ADDR = 2'd1, R_DATA = 2'd2} r_state_t;

    w_state_t          w_state_r, w_state_s;
    r_state_t          r_state_r, r_state_s;
    logic [IDX_W-1:0]  wgnt_r, wgnt_s, wptr_r, wptr_s;
    logic [IDX_W-1:0]  rgnt_r, rgnt_s, rptr_r, rptr_s;
    logic              aw_done_r, aw_done_s, w_done_r, w_done_s;
    logic              aw_hs_s, wlast_hs_s;

    // First requester with a pending valid at or after ptr, scanning cyclically.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] vld,
                                                 input logic [IDX_W-1:0] ptr);
        logic [IDX_W-1:0] pick;
        logic             found;
        int               idx;
        pick  = ptr;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && vld[idx]) begin
                pick  = IDX_W'(idx);
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

    // Pointer that follows grant g, wrapping NUM_REQ-1 back to 0.
    function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] g);
        return (int'(g) == NUM_REQ - 1) ? {IDX_W{1'b0}} : IDX_W'(int'(g) + 1);
    endfunction

    // Master payloads always follow the registered grants; valids gate their use.
    assign m_awid     = s_awid[int'(wgnt_r)*ID_W +: ID_W];
    assign m_awaddr   = s_awaddr[int'(wgnt_r)*ADDR_W +: ADDR_W];
    assign m_awlen    = s_awlen[int'(wgnt_r)*LEN_W +: LEN_W];
    assign m_awsize   = s_awsize[int'(wgnt_r)*3 +: 3];
    assign m_awburst  = s_awburst[int'(wgnt_r)*2 +: 2];
    assign m_wdata    = s_wdata[int'(wgnt_r)*DATA_W +: DATA_W];
    assign m_wstrb    = s_wstrb[int'(wgnt_r)*STRB_W +: STRB_W];
    assign m_wlast    = s_wlast[wgnt_r];
    assign m_arid     = s_arid[int'(rgnt_r)*ID_W +: ID_W];
    assign m_araddr   = s_araddr[int'(rgnt_r)*ADDR_W +: ADDR_W];
    assign m_arlen    = s_arlen[int'(rgnt_r)*LEN_W +: LEN_W];
    assign m_arsize   = s_arsize[int'(rgnt_r)*3 +: 3];
    assign m_arburst  = s_arburst[int'(rgnt_r)*2 +: 2];
    assign m_awlock   = 1'b0;
    assign m_awcache  = 4'b0011;
    assign m_awprot   = 3'b000;
    assign m_awqos    = 4'b0000;
    assign m_awregion = 4'b0000;
    assign m_awuser   = 1'b0;
    assign m_arlock   = 1'b0;
    assign m_arcache  = 4'b0011;
    assign m_arprot   = 3'b000;
    assign m_arqos    = 4'b0000;
    assign m_arregion = 4'b0000;
    assign m_aruser   = 1'b0;

    // Response payloads are broadcast; only the one-hot valid selects the owner.
    assign s_bid   = {NUM_REQ{m_bid}};
    assign s_bresp = {NUM_REQ{m_bresp}};
    assign s_rid   = {NUM_REQ{m_rid}};
    assign s_rdata = {NUM_REQ{m_rdata}};
    assign s_rresp = {NUM_REQ{m_rresp}};
    assign s_rlast = {NUM_REQ{m_rlast}};

    assign aw_hs_s    = (w_state_r == W_BUSY) & s_awvalid[wgnt_r] & ~aw_done_r & m_awready;
    assign wlast_hs_s = (w_state_r == W_BUSY) & s_wvalid[wgnt_r] & ~w_done_r & m_wready
                        & s_wlast[wgnt_r];

    // Write FSM next state and AW/W/B handshake steering.
    always_comb begin
        w_state_s = w_state_r;
        wgnt_s    = wgnt_r;
        wptr_s    = wptr_r;
        aw_done_s = aw_done_r;
        w_done_s  = w_done_r;
        m_awvalid = 1'b0;
        m_wvalid  = 1'b0;
        m_bready  = 1'b0;
        s_awready = {NUM_REQ{1'b0}};
        s_wready  = {NUM_REQ{1'b0}};
        s_bvalid  = {NUM_REQ{1'b0}};
        case (w_state_r)
            W_IDLE: begin
                if (|s_awvalid) begin
                    wgnt_s    = rr_pick(s_awvalid, wptr_r);
                    aw_done_s = 1'b0;
                    w_done_s  = 1'b0;
                    w_state_s = W_BUSY;
                end else begin
                    w_state_s = W_IDLE;
                end
            end
            W_BUSY: begin
                m_awvalid         = s_awvalid[wgnt_r] & ~aw_done_r;
                s_awready[wgnt_r] = m_awready & ~aw_done_r;
                m_wvalid          = s_wvalid[wgnt_r] & ~w_done_r;
                s_wready[wgnt_r]  = m_wready & ~w_done_r;
                aw_done_s         = aw_done_r | aw_hs_s;
                w_done_s          = w_done_r | wlast_hs_s;
                if (aw_done_s && w_done_s) begin
                    w_state_s = W_RESP;
                end else begin
                    w_state_s = W_BUSY;
                end
            end
            W_RESP: begin
                s_bvalid[wgnt_r] = m_bvalid;
                m_bready         = s_bready[wgnt_r];
                if (m_bvalid && s_bready[wgnt_r]) begin
                    wptr_s    = rr_next(wgnt_r);
                    w_state_s = W_IDLE;
                end else begin
                    w_state_s = W_RESP;
                end
            end
            default: w_state_s = W_IDLE;
        endcase
    end

    // Read FSM next state and AR/R handshake steering.
    always_comb begin
        r_state_s = r_state_r;
        rgnt_s    = rgnt_r;
        rptr_s    = rptr_r;
        m_arvalid = 1'b0;
        m_rready  = 1'b0;
        s_arready = {NUM_REQ{1'b0}};
        s_rvalid  = {NUM_REQ{1'b0}};
        case (r_state_r)
            R_IDLE: begin
                if (|s_arvalid) begin
                    rgnt_s    = rr_pick(s_arvalid, rptr_r);
                    r_state_s = R_ADDR;
                end else begin
                    r_state_s = R_IDLE;
                end
            end
            R_ADDR: begin
                m_arvalid         = 1'b1;
                s_arready[rgnt_r] = m_arready;
                if (m_arready) begin
                    r_state_s = R_DATA;
                end else begin
                    r_state_s = R_ADDR;
                end
            end
            R_DATA: begin
                s_rvalid[rgnt_r] = m_rvalid;
                m_rready         = s_rready[rgnt_r];
                if (m_rvalid && s_rready[rgnt_r] && m_rlast) begin
                    rptr_s    = rr_next(rgnt_r);
                    r_state_s = R_IDLE;
                end else begin
                    r_state_s = R_DATA;
                end
            end
            default: r_state_s = R_IDLE;
        endcase
    end

    // State, grant and pointer registers; reset abandons any burst in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_state_r <= W_IDLE;
            r_state_r <= R_IDLE;
            wgnt_r    <= {IDX_W{1'b0}};
            wptr_r    <= {IDX_W{1'b0}};
            rgnt_r    <= {IDX_W{1'b0}};
            rptr_r    <= {IDX_W{1'b0}};
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
        end else begin
            w_state_r <= w_state_s;
            r_state_r <= r_state_s;
            wgnt_r    <= wgnt_s;
            wptr_r    <= wptr_s;
            rgnt_r    <= rgnt_s;
            rptr_r    <= rptr_s;
            aw_done_r <= aw_done_s;
            w_done_r  <= w_done_s;
        end
    end
endmodule

// File: tb/tb_axi_rr_arbiter.sv
// Directed-plus-random bench for axi_rr_arbiter. Expected grants come from a
// round-robin model (pointer per direction, cyclic scan) kept in the bench.
module tb_axi_rr_arbiter;
    localparam int NR = 2, IW = 4, AW = 32, DW = 32, LW = 8, SW = DW / 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NR*IW-1:0] s_awid, s_arid, s_bid, s_rid;
    logic [NR*AW-1:0] s_awaddr, s_araddr;
    logic [NR*LW-1:0] s_awlen, s_arlen;
    logic [NR*3-1:0]  s_awsize, s_arsize;
    logic [NR*2-1:0]  s_awburst, s_arburst, s_bresp, s_rresp;
    logic [NR-1:0]    s_awvalid, s_awready, s_wlast, s_wvalid, s_wready, s_bvalid, s_bready;
    logic [NR-1:0]    s_arvalid, s_arready, s_rlast, s_rvalid, s_rready;
    logic [NR*DW-1:0] s_wdata, s_rdata;
    logic [NR*SW-1:0] s_wstrb;
    logic [IW-1:0]    m_awid, m_arid, m_bid, m_rid;
    logic [AW-1:0]    m_awaddr, m_araddr;
    logic [LW-1:0]    m_awlen, m_arlen;
    logic [2:0]       m_awsize, m_arsize, m_awprot, m_arprot;
    logic [1:0]       m_awburst, m_arburst, m_bresp, m_rresp;
    logic [3:0]       m_awcache, m_arcache, m_awqos, m_arqos, m_awregion, m_arregion;
    logic [0:0]       m_awuser, m_aruser;
    logic             m_awlock, m_arlock, m_awvalid, m_awready, m_wlast, m_wvalid, m_wready;
    logic             m_bvalid, m_bready, m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;
    logic [DW-1:0]    m_wdata, m_rdata;
    logic [SW-1:0]    m_wstrb;

    int total = 0;
    int bad = 0;
    int wptr_m = 0;
    int rptr_m = 0;
    logic [AW-1:0] aw_addr [NR];
    logic [AW-1:0] ar_addr [NR];

    axi_rr_arbiter #(.NUM_REQ(NR), .ID_W(IW), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
        .s_awburst(s_awburst), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid),
        .s_wready(s_wready), .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid),
        .s_bready(s_bready), .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen),
        .s_arsize(s_arsize), .s_arburst(s_arburst), .s_arvalid(s_arvalid),
        .s_arready(s_arready), .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
        .m_awburst(m_awburst), .m_awlock(m_awlock), .m_awcache(m_awcache),
        .m_awprot(m_awprot), .m_awqos(m_awqos), .m_awregion(m_awregion),
        .m_awuser(m_awuser), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid),
        .m_wready(m_wready), .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid),
        .m_bready(m_bready), .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen),
        .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arlock(m_arlock),
        .m_arcache(m_arcache), .m_arprot(m_arprot), .m_arqos(m_arqos),
        .m_arregion(m_arregion), .m_aruser(m_aruser), .m_arvalid(m_arvalid),
        .m_arready(m_arready), .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp),
        .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Round-robin rule: first requester with valid at or after ptr, cyclically.
    function automatic int pick(input logic [NR-1:0] v, input int ptr);
        for (int k = 0; k < NR; k++) begin
            if (v[(ptr + k) % NR]) return (ptr + k) % NR;
        end
        return 0;
    endfunction

    function automatic logic [NR-1:0] oh(input int g);
        logic [NR-1:0] v;
        v = '0;
        v[g] = 1'b1;
        return v;
    endfunction

    task automatic clear_inputs();
        s_awid = '0; s_awaddr = '0; s_awlen = '0; s_awsize = '0; s_awburst = '0; s_awvalid = '0;
        s_wdata = '0; s_wstrb = '0; s_wlast = '0; s_wvalid = '0; s_bready = '0;
        s_arid = '0; s_araddr = '0; s_arlen = '0; s_arsize = '0; s_arburst = '0; s_arvalid = '0;
        s_rready = '0; m_awready = 1'b0; m_wready = 1'b0; m_bid = '0; m_bresp = '0;
        m_bvalid = 1'b0; m_arready = 1'b0; m_rid = '0; m_rdata = '0; m_rresp = '0;
        m_rlast = 1'b0; m_rvalid = 1'b0;
    endtask

    // One write burst: AW from requesters in vmask, nbeats W beats, then B.
    // w_first: all W beats complete before AW (then gap stall cycles);
    // otherwise the last W beat handshakes in the same cycle as AW.
    task automatic write_burst(input logic [NR-1:0] vmask, input int nbeats, input bit w_first,
                               input int gap, input logic [1:0] bresp);
        int g;
        logic [DW-1:0] d;
        logic [IW-1:0] bid;
        for (int r = 0; r < NR; r++) begin
            aw_addr[r] = $urandom;
            s_awaddr[r*AW +: AW] = aw_addr[r];
            s_awlen[r*LW +: LW] = LW'(nbeats - 1);
        end
        s_awvalid = vmask;
        g = pick(vmask, wptr_m);
        settle();
        chk("aw_idle", m_awvalid, 0);
        step();
        chk("aw_valid", m_awvalid, 1);
        chk("aw_addr", m_awaddr, aw_addr[g]);
        chk("aw_len", m_awlen, nbeats - 1);
        m_wready = 1'b1;
        for (int b = 0; b < nbeats - (w_first ? 0 : 1); b++) begin
            d = $urandom;
            s_wvalid = oh(g);
            s_wdata[g*DW +: DW] = d;
            s_wlast = (b == nbeats - 1) ? oh(g) : '0;
            settle();
            chk("w_data", m_wdata, d);
            chk("w_ready", s_wready, oh(g));
            chk("aw_wait", s_awready, 0);
            step();
        end
        if (w_first) begin
            s_bready = '1;
            for (int c = 0; c < gap; c++) begin
                settle();
                chk("w_done_gate", s_wready, 0);
                chk("no_early_resp", m_bready, 0);
                step();
            end
            s_wvalid = '0;
            m_awready = 1'b1;
            settle();
            chk("aw_ready", s_awready, oh(g));
            step();
        end else begin
            d = $urandom;
            s_wvalid = oh(g);
            s_wlast = oh(g);
            s_wdata[g*DW +: DW] = d;
            m_awready = 1'b1;
            settle();
            chk("aw_ready_same", s_awready, oh(g));
            chk("w_ready_same", s_wready, oh(g));
            chk("w_data_last", m_wdata, d);
            step();
        end
        m_awready = 1'b0; m_wready = 1'b0; s_wvalid = '0; s_wlast = '0; s_awvalid = '0;
        bid = IW'($urandom);
        m_bvalid = 1'b1; m_bresp = bresp; m_bid = bid; s_bready = '0;
        settle();
        chk("b_valid", s_bvalid, oh(g));
        chk("b_stall", m_bready, 0);
        s_bready = '1;
        settle();
        chk("b_ready", m_bready, 1);
        chk("b_resp", s_bresp[g*2 +: 2], bresp);
        chk("b_id", s_bid[g*IW +: IW], bid);
        step();
        m_bvalid = 1'b0; s_bready = '0;
        wptr_m = (g + 1) % NR;
        settle();
        chk("b_done", s_bvalid, 0);
    endtask

    // One read burst of nbeats beats; optional one-cycle requester stall on beat 0.
    task automatic read_burst(input logic [NR-1:0] vmask, input int nbeats, input bit stall);
        int g;
        logic [DW-1:0] d;
        for (int r = 0; r < NR; r++) begin
            ar_addr[r] = $urandom;
            s_araddr[r*AW +: AW] = ar_addr[r];
            s_arlen[r*LW +: LW] = LW'(nbeats - 1);
        end
        s_arvalid = vmask;
        g = pick(vmask, rptr_m);
        settle();
        chk("ar_idle", m_arvalid, 0);
        step();
        chk("ar_valid", m_arvalid, 1);
        chk("ar_addr", m_araddr, ar_addr[g]);
        chk("ar_len", m_arlen, nbeats - 1);
        m_arready = 1'b1;
        settle();
        chk("ar_ready", s_arready, oh(g));
        step();
        m_arready = 1'b0; s_arvalid = '0;
        for (int b = 0; b < nbeats; b++) begin
            d = $urandom;
            m_rvalid = 1'b1; m_rdata = d; m_rlast = (b == nbeats - 1);
            if (stall && b == 0) begin
                s_rready = '0;
                settle();
                chk("r_stall", m_rready, 0);
                chk("r_valid_stall", s_rvalid, oh(g));
                step();
            end
            s_rready = '1;
            settle();
            chk("r_valid", s_rvalid, oh(g));
            chk("r_ready", m_rready, 1);
            chk("r_data", s_rdata[g*DW +: DW], d);
            step();
        end
        m_rvalid = 1'b0; m_rlast = 1'b0; s_rready = '0;
        rptr_m = (g + 1) % NR;
        settle();
        chk("r_done", s_rvalid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int gr, gw;
        logic [DW-1:0] d;
        logic [NR-1:0] vm;
        clear_inputs();
        rst_n = 1'b0;
        step();
        step();
        chk("rst_awvalid", m_awvalid, 0);
        chk("rst_arvalid", m_arvalid, 0);
        chk("rst_wvalid", m_wvalid, 0);
        chk("rst_bready", m_bready, 0);
        chk("rst_rready", m_rready, 0);
        chk("rst_s_ready", {s_awready, s_wready, s_arready, s_bvalid, s_rvalid}, 0);
        chk("aw_cache", m_awcache, 4'b0011);
        chk("ar_cache", m_arcache, 4'b0011);
        rst_n = 1'b1;
        step();

        // Lone req0 read, then both requesting: pointer must have moved to req1.
        read_burst(2'b01, 4, 1'b1);
        read_burst(2'b11, 1, 1'b0);

        // Two requesters contending for writes: 0, 1, 0.
        write_burst(2'b11, 2, 1'b0, 0, 2'b00);
        write_burst(2'b11, 1, 1'b0, 0, 2'b00);
        write_burst(2'b11, 1, 1'b0, 0, 2'b01);

        // Req1 W ahead of AW, then same-cycle AW/WLAST with SLVERR.
        write_burst(2'b10, 1, 1'b1, 2, 2'b00);
        write_burst(2'b11, 1, 1'b0, 0, 2'b10);

        // Concurrent read (req0) and write (req1).
        ar_addr[0] = $urandom; s_araddr[0 +: AW] = ar_addr[0]; s_arlen[0 +: LW] = '0;
        aw_addr[1] = $urandom; s_awaddr[AW +: AW] = aw_addr[1]; s_awlen[LW +: LW] = '0;
        s_arvalid = 2'b01; s_awvalid = 2'b10;
        gr = pick(2'b01, rptr_m); gw = pick(2'b10, wptr_m);
        step();
        chk("cc_arvalid", m_arvalid, 1);
        chk("cc_awvalid", m_awvalid, 1);
        chk("cc_araddr", m_araddr, ar_addr[gr]);
        chk("cc_awaddr", m_awaddr, aw_addr[gw]);
        d = $urandom;
        m_arready = 1'b1; m_awready = 1'b1; m_wready = 1'b1;
        s_wvalid = oh(gw); s_wlast = oh(gw); s_wdata[gw*DW +: DW] = d;
        settle();
        chk("cc_arready", s_arready, oh(gr));
        chk("cc_awready", s_awready, oh(gw));
        chk("cc_wready", s_wready, oh(gw));
        step();
        m_arready = 1'b0; m_awready = 1'b0; m_wready = 1'b0;
        s_wvalid = '0; s_wlast = '0; s_arvalid = '0; s_awvalid = '0;
        d = $urandom;
        m_rvalid = 1'b1; m_rlast = 1'b1; m_rdata = d; m_bvalid = 1'b1; m_bresp = 2'b00;
        s_rready = '0; s_bready = '0;
        settle();
        chk("cc_rready_bp", m_rready, 0);
        chk("cc_bready_bp", m_bready, 0);
        chk("cc_rvalid", s_rvalid, oh(gr));
        chk("cc_bvalid", s_bvalid, oh(gw));
        s_rready = oh(gr); s_bready = oh(gw);
        settle();
        chk("cc_rready", m_rready, 1);
        chk("cc_bready", m_bready, 1);
        step();
        m_rvalid = 1'b0; m_rlast = 1'b0; m_bvalid = 1'b0; s_rready = '0; s_bready = '0;
        rptr_m = (gr + 1) % NR; wptr_m = (gw + 1) % NR;

        // Randomized bursts against the round-robin model.
        for (int i = 0; i < 8; i++) begin
            vm = NR'($urandom_range(1, (1 << NR) - 1));
            if ($urandom_range(0, 1) == 0) begin
                read_burst(vm, $urandom_range(1, 4), 1'($urandom_range(0, 1)));
            end else begin
                write_burst(vm, $urandom_range(1, 3), 1'($urandom_range(0, 1)),
                            $urandom_range(0, 2), 2'($urandom_range(0, 3)));
            end
        end

        // Move both pointers to 1, then reset during beat 2 of an 8-beat read.
        read_burst(2'b01, 1, 1'b0);
        write_burst(2'b01, 1, 1'b0, 0, 2'b00);
        ar_addr[0] = $urandom; s_araddr[0 +: AW] = ar_addr[0]; s_arlen[0 +: LW] = 8'd7;
        s_arvalid = 2'b01;
        step();
        m_arready = 1'b1;
        step();
        m_arready = 1'b0; s_arvalid = '0;
        m_rvalid = 1'b1; s_rready = '1;
        step();
        step();
        settle();
        chk("mid_burst_rvalid", s_rvalid, 2'b01);
        rst_n = 1'b0;
        step();
        chk("rst_mid_rvalid", s_rvalid, 0);
        chk("rst_mid_rready", m_rready, 0);
        chk("rst_mid_arvalid", m_arvalid, 0);
        chk("rst_mid_awvalid", m_awvalid, 0);
        chk("rst_mid_arready", s_arready, 0);
        rst_n = 1'b1; m_rvalid = 1'b0; s_rready = '0;
        rptr_m = 0; wptr_m = 0;
        step();
        read_burst(2'b11, 1, 1'b0);
        write_burst(2'b11, 1, 1'b0, 0, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
